// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised data RAM with RV32I load/store sizing and a
// valid/ready request port. Fixed-latency, in-order responses with error flag.
//
// Parameters:
//   DEPTH    number of 32-bit words (word index = addr[31:2])
//   LATENCY  cycles from accept to response, 1..4
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready  request handshake, transfer on rising clk
//   req_we, req_funct3   store/load select and RV32I size/sign code
//   req_addr, req_wdata  byte address, right-aligned store data
//   rsp_valid            one-cycle response strobe
//   rsp_rdata, rsp_err   extended load data (0 on store/error), error flag
//
// Build option:
//   DMEM_LSU_PIPE_EN  fully pipelined, req_ready always 1, up to LATENCY in
//                     flight. Undefined: single-outstanding request FSM.
module dmem_lsu #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    logic          accept;
    logic [AW-1:0] idx;
    logic          legal;
    logic          misaligned;
    logic          in_range;
    logic          err;
    logic [31:0]   rd_word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic [31:0]   rsp_data_in;

    assign accept   = req_valid & req_ready;
    assign idx      = req_addr[AW+1:2];
    assign in_range = req_addr[31:2] < 30'(DEPTH);
    assign err      = ~legal | misaligned | ~in_range;
    assign rd_word  = mem[idx];
    assign shifted  = rd_word >> {req_addr[1:0], 3'b000};

    // funct3 legality and alignment; unsigned loads are illegal as stores
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        case (req_funct3)
            3'b000: legal = 1'b1;
            3'b001: begin
                legal      = 1'b1;
                misaligned = req_addr[0];
            end
            3'b010: begin
                legal      = 1'b1;
                misaligned = |req_addr[1:0];
            end
            3'b100, 3'b101: begin
                legal      = ~req_we;
                misaligned = req_funct3[0] & req_addr[0];
            end
            default: legal = 1'b0;
        endcase
    end

    // Load extraction; half-word shift by addr[1:0] is safe since addr[0]=0
    always_comb begin
        load_data = '0;
        case (req_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    // Store data replicated across lanes; byte enables pick the lane(s)
    always_comb begin
        wr_data = req_wdata;
        wr_be   = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                wr_data = {4{req_wdata[7:0]}};
                wr_be   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wr_data = {2{req_wdata[15:0]}};
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = req_wdata;
                wr_be   = 4'b1111;
            end
        endcase
    end

    assign rsp_data_in = (err || req_we) ? 32'd0 : load_data;

    // RAM array: not reset, contents survive reset
    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Response shift register; data stages load only behind a valid so the
    // final stage holds its last response while rsp_valid is low
    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_err;
    logic [31:0]        pipe_data [LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            if (accept) begin
                pipe_err[0]  <= err;
                pipe_data[0] <= rsp_data_in;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_err[i]  <= pipe_err[i-1];
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign rsp_valid = pipe_valid[LATENCY-1];
    assign rsp_err   = pipe_err[LATENCY-1];
    assign rsp_rdata = pipe_data[LATENCY-1];

`ifdef DMEM_LSU_PIPE_EN
    assign req_ready = 1'b1;
`else
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ready_q;
    logic          ready_d;

    // State, countdown and registered ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // cnt==0 in WAIT is the response cycle, which may accept again
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && (LATENCY > 1)) begin
                    state_d = WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (accept) begin
                    cnt_d = CW'(LATENCY - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || (cnt_d == '0);
    end

    assign req_ready = ready_q;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=1 instance
    logic        rst1, v1, we1, rdy1, rv1, re1;
    logic [2:0]  f1;
    logic [31:0] a1, w1, rd1;
    // LATENCY=3 instance
    logic        rst3, v3, we3, rdy3, rv3, re3;
    logic [2:0]  f3;
    logic [31:0] a3, w3, rd3;

    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
        .req_funct3(f1), .req_addr(a1), .req_wdata(w1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
    );

    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
        .req_funct3(f3), .req_addr(a3), .req_wdata(w3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // byte-level model of the LATENCY=1 instance's RAM
    byte unsigned mm [DEPTH*4];
    logic [31:0]  last_rd1;
    logic         last_err1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: size/sign/legality from funct3, byte-array RAM
    function automatic void model(input logic we, input logic [2:0] fn, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rd);
        longint a;
        longint val;
        int     n;
        bit     lg;
        a  = longint'(addr);
        lg = we ? (fn <= 3'd2) : (fn <= 3'd2 || fn == 3'd4 || fn == 3'd5);
        n  = (fn[1:0] == 2'd0) ? 1 : ((fn[1:0] == 2'd1) ? 2 : 4);
        err = !lg || ((a % n) != 0) || ((a / 4) >= DEPTH);
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mm[a+i] = wd[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < n; i++) val += longint'(mm[a+i]) << (8*i);
                if (!fn[2] && n < 4 && val >= (longint'(1) << (8*n-1)))
                    val -= longint'(1) << (8*n);
                rd = val[31:0];
            end
        end
    endfunction

    task automatic op1(input string name, input logic we, input logic [2:0] fn, input logic [31:0] addr,
                       input logic [31:0] wd, input logic xe, input logic [31:0] xr);
        v1 = 1'b1; we1 = we; f1 = fn; a1 = addr; w1 = wd;
        chk({name, " ready"}, 32'(rdy1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        chk({name, " valid"}, 32'(rv1), 32'd1);
        chk({name, " err"}, 32'(re1), 32'(xe));
        chk({name, " rdata"}, rd1, xr);
        last_rd1  = xr;
        last_err1 = xe;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  fn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic        v;
        logic        we;
        logic [2:0]  fn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        rv;
        logic        err;
        logic [31:0] rd;
    } cyc_t;

`ifdef DMEM_LSU_PIPE_EN
    localparam logic [31:0] RST_ADDR = 32'h20;
    localparam logic [31:0] RST_DATA = 32'h55;
`else
    localparam logic [31:0] RST_ADDR = 32'h8;
    localparam logic [31:0] RST_DATA = 32'hCAFE_F00D;
`endif

    initial begin
        vec_t        tbl [17];
        cyc_t        seq [12];
        int          nseq;
        logic        xe;
        logic [31:0] xr;
        logic        rwe;
        logic [2:0]  rfn;
        logic [31:0] raddr;
        logic [31:0] rwd;
        logic [2:0]  legal_fn [5];

        legal_fn = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        tbl[0]  = '{1'b1, 3'b010, 32'h10, 32'h8000_00F0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFF_FFF0};
        tbl[2]  = '{1'b0, 3'b100, 32'h10, 32'h0, 1'b0, 32'h0000_00F0};
        tbl[3]  = '{1'b1, 3'b000, 32'h13, 32'h0000_00AB, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hAB00_00F0};
        tbl[5]  = '{1'b1, 3'b001, 32'h12, 32'h0000_1234, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_1234};
        tbl[7]  = '{1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1234_00F0};
        tbl[9]  = '{1'b1, 3'b010, 32'(DEPTH*4), 32'hDEAD_BEEF, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'h0000_1234};
        tbl[12] = '{1'b1, 3'b000, 32'h11, 32'hFFFF_FF80, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFF_80F0};
        tbl[14] = '{1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000_80F0};
        tbl[15] = '{1'b1, 3'b100, 32'h10, 32'h1, 1'b1, 32'h0};
        tbl[16] = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1234_80F0};

`ifdef DMEM_LSU_PIPE_EN
        nseq = 8;
        seq[0] = '{1'b1, 1'b1, 3'b010, 32'h20, 32'h55, 1'b1, 1'b0, 1'b0, 32'h0};
        seq[1] = '{1'b1, 1'b1, 3'b010, 32'h24, 32'h77, 1'b1, 1'b0, 1'b0, 32'h0};
        seq[2] = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        seq[3] = '{1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
        seq[4] = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
        seq[5] = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h55};
        seq[6] = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h77};
        seq[7] = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h77};
`else
        nseq = 11;
        seq[0]  = '{1'b1, 1'b1, 3'b010, 32'h8, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0};
        seq[1]  = '{1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        seq[2]  = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        seq[3]  = '{1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
        seq[4]  = '{1'b1, 1'b0, 3'b000, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        seq[5]  = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        seq[6]  = '{1'b1, 1'b0, 3'b001, 32'h9, 32'h0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D};
        seq[7]  = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D};
        seq[8]  = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D};
        seq[9]  = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0};
        seq[10] = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0};
`endif

        rst1 = 1'b0; v1 = 1'b0; we1 = 1'b0; f1 = 3'd0; a1 = 32'd0; w1 = 32'd0;
        rst3 = 1'b0; v3 = 1'b0; we3 = 1'b0; f3 = 3'd0; a3 = 32'd0; w3 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset1 ready", 32'(rdy1), 32'd1);
        chk("reset1 valid", 32'(rv1), 32'd0);
        chk("reset1 err", 32'(re1), 32'd0);
        chk("reset1 rdata", rd1, 32'd0);
        chk("reset3 ready", 32'(rdy3), 32'd1);
        chk("reset3 valid", 32'(rv3), 32'd0);
        rst1 = 1'b1;
        rst3 = 1'b1;

        // Fill RAM so the model knows every byte
        for (int w = 0; w < DEPTH; w++) begin
            rwd = $urandom();
            model(1'b1, 3'b010, 32'(w*4), rwd, xe, xr);
            op1("init sw", 1'b1, 3'b010, 32'(w*4), rwd, xe, xr);
        end

        // Directed vectors, model kept in step
        for (int i = 0; i < 17; i++) begin
            model(tbl[i].we, tbl[i].fn, tbl[i].addr, tbl[i].wd, xe, xr);
            op1($sformatf("vec%0d", i), tbl[i].we, tbl[i].fn, tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].rd);
        end

        // Randomised traffic with idle gaps
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                v1 = 1'b0;
                @(posedge clk); #1;
                chk("idle valid", 32'(rv1), 32'd0);
                chk("idle hold rdata", rd1, last_rd1);
                chk("idle hold err", 32'(re1), 32'(last_err1));
            end else begin
                rwe = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) rfn = 3'($urandom_range(0, 7));
                else rfn = legal_fn[$urandom_range(0, 4)];
                raddr = 32'($urandom_range(0, DEPTH*4 - 1));
                if ($urandom_range(0, 1) == 1) raddr = raddr & ~32'(3);
                if ($urandom_range(0, 15) == 0) raddr = $urandom();
                rwd = $urandom();
                model(rwe, rfn, raddr, rwd, xe, xr);
                op1("rand", rwe, rfn, raddr, rwd, xe, xr);
            end
        end

        // LATENCY=3 cycle-accurate sequence
        for (int c = 0; c < nseq; c++) begin
            v3 = seq[c].v; we3 = seq[c].we; f3 = seq[c].fn; a3 = seq[c].addr; w3 = seq[c].wd;
            chk($sformatf("lat3 c%0d ready", c), 32'(rdy3), 32'(seq[c].rdy));
            chk($sformatf("lat3 c%0d valid", c), 32'(rv3), 32'(seq[c].rv));
            chk($sformatf("lat3 c%0d err", c), 32'(re3), 32'(seq[c].err));
            chk($sformatf("lat3 c%0d rdata", c), rd3, seq[c].rd);
            @(posedge clk); #1;
        end
        v3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during an in-flight load drops it; RAM survives
        v3 = 1'b1; we3 = 1'b0; f3 = 3'b010; a3 = RST_ADDR;
        chk("rst-mid c0 ready", 32'(rdy3), 32'd1);
        @(posedge clk); #1;
        v3 = 1'b0;
        rst3 = 1'b0;
        #1;
        chk("rst-mid during ready", 32'(rdy3), 32'd1);
        chk("rst-mid during valid", 32'(rv3), 32'd0);
        chk("rst-mid during rdata", rd3, 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            chk($sformatf("rst-mid c%0d valid", c), 32'(rv3), 32'd0);
            chk($sformatf("rst-mid c%0d ready", c), 32'(rdy3), 32'd1);
            if (c < 5) begin
                @(posedge clk); #1;
            end
        end
        v3 = 1'b1; we3 = 1'b0; f3 = 3'b010; a3 = RST_ADDR;
        @(posedge clk); #1;
        v3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post-rst load valid", 32'(rv3), 32'd1);
        chk("post-rst load err", 32'(re3), 32'd0);
        chk("post-rst load rdata", rd3, RST_DATA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
